// File: rtl/fade_volume_ctrl.sv
// fade_volume_ctrl: volume register, gain tracking and sample scaler for the codec path.
// Build option FADE_SOFT_RAMP_EN: gain walks one step per RAMP_DIV frames instead of jumping.
module fade_volume_ctrl #(
    parameter int unsigned RAMP_DIV  = 64,
    parameter int unsigned VOL_RESET = 12
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        new_frame_i,
    input  logic [15:0] sample_in_i,
    input  logic        vol_up_i,
    input  logic        vol_down_i,
    input  logic        mute_i,
    output logic [15:0] sample_out_o,
    output logic        sample_valid_o,
    output logic [4:0]  volume_o,
    output logic [4:0]  gain_o,
    output logic        ramping_o
);
    localparam logic [4:0] VOL_MAX = 5'd16;
    localparam logic [4:0] VOL_RST = 5'(VOL_RESET);

    if (RAMP_DIV < 1 || RAMP_DIV > 255) begin : g_bad_ramp_div
        $error("fade_volume_ctrl: RAMP_DIV must be in 1..255");
    end
    if (VOL_RESET > 16) begin : g_bad_vol_reset
        $error("fade_volume_ctrl: VOL_RESET must be in 0..16");
    end

    logic [4:0]         volume_q, volume_d;
    logic [4:0]         gain_q, gain_d;
    logic [4:0]         target;
    logic [15:0]        sample_out_q, sample_d;
    logic               sample_valid_q;
    logic signed [21:0] product;

    assign target = mute_i ? 5'd0 : volume_q;

    // gain <= 16 keeps (sample * gain) >>> 4 inside the 16-bit signed range
    assign product  = $signed({{6{sample_in_i[15]}}, sample_in_i}) * $signed({17'd0, gain_q});
    assign sample_d = 16'(product >>> 4);

    always_comb begin
        volume_d = volume_q;
        if (vol_up_i && !vol_down_i && volume_q != VOL_MAX) begin
            volume_d = volume_q + 5'd1;
        end else if (vol_down_i && !vol_up_i && volume_q != 5'd0) begin
            volume_d = volume_q - 5'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            volume_q       <= VOL_RST;
            gain_q         <= VOL_RST;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            volume_q       <= volume_d;
            gain_q         <= gain_d;
            sample_valid_q <= new_frame_i;
            if (new_frame_i) begin
                sample_out_q <= sample_d;
            end
        end
    end

`ifdef FADE_SOFT_RAMP_EN
    typedef enum logic [1:0] {
        STEADY,
        RAMP_UP,
        RAMP_DOWN
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(RAMP_DIV - 1);

    state_t     state_now, state_q;
    logic [7:0] div_q, div_d;

    function automatic state_t classify(input logic [4:0] g, input logic [4:0] t);
        if (g < t) return RAMP_UP;
        if (g > t) return RAMP_DOWN;
        return STEADY;
    endfunction

    assign state_now = classify(gain_q, target);

    // divider survives a direction reversal; only reaching the target clears it
    always_comb begin
        gain_d = gain_q;
        div_d  = div_q;
        if (state_now == STEADY) begin
            div_d = '0;
        end else if (new_frame_i) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                gain_d = (state_now == RAMP_UP) ? gain_q + 5'd1 : gain_q - 5'd1;
            end else begin
                div_d = div_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_q   <= '0;
            state_q <= STEADY;
        end else begin
            div_q   <= div_d;
            state_q <= classify(gain_d, target);
        end
    end

    assign ramping_o = (state_q != STEADY);
`else
    always_comb begin
        gain_d = gain_q;
        if (new_frame_i) begin
            gain_d = target;
        end
    end

    assign ramping_o = 1'b0;
`endif

    assign sample_out_o   = sample_out_q;
    assign sample_valid_o = sample_valid_q;
    assign volume_o       = volume_q;
    assign gain_o         = gain_q;

endmodule

// File: tb/tb_fade_volume_ctrl.sv
// Self-checking bench for fade_volume_ctrl: directed scenarios plus randomized traffic
// compared every cycle against an arithmetic model of volume, gain and scaling.
module tb_fade_volume_ctrl;
    localparam int unsigned TB_DIV = 2;
`ifdef FADE_SOFT_RAMP_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        nf   = 1'b0;
    logic        up   = 1'b0;
    logic        dn   = 1'b0;
    logic        mute = 1'b0;
    logic [15:0] s_in = '0;
    logic [15:0] s_out;
    logic        s_valid;
    logic [4:0]  vol, gain;
    logic        ramping;

    int n_checks = 0;
    int n_pass   = 0;

    int          m_vol, m_gain, m_div;
    logic [15:0] m_out;
    bit          m_valid, m_ramp;

    always #5 clk = ~clk;

    fade_volume_ctrl #(.RAMP_DIV(TB_DIV), .VOL_RESET(12)) dut (
        .clk_i(clk), .reset_i(rst), .new_frame_i(nf), .sample_in_i(s_in),
        .vol_up_i(up), .vol_down_i(dn), .mute_i(mute),
        .sample_out_o(s_out), .sample_valid_o(s_valid), .volume_o(vol),
        .gain_o(gain), .ramping_o(ramping)
    );

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, got, got, want, want, $time);
    endtask

    task automatic model_reset();
        m_vol = 12; m_gain = 12; m_div = 0;
        m_out = '0; m_valid = 1'b0; m_ramp = 1'b0;
    endtask

    // One clock edge of the reference behaviour, from the inputs present at that edge.
    task automatic model_edge();
        int tgt, prod;
        if (rst) begin
            model_reset();
            return;
        end
        tgt = mute ? 0 : m_vol;
        if (nf) begin
            prod    = int'($signed(s_in)) * m_gain;
            m_out   = 16'(prod >>> 4);
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (SOFT) begin
            if (m_gain == tgt) m_div = 0;
            else if (nf) begin
                if (m_div == TB_DIV - 1) begin
                    m_div  = 0;
                    m_gain = (m_gain < tgt) ? m_gain + 1 : m_gain - 1;
                end else m_div++;
            end
            m_ramp = (m_gain != tgt);
        end else begin
            if (nf) m_gain = tgt;
            m_ramp = 1'b0;
        end
        if (up && !dn) m_vol = (m_vol < 16) ? m_vol + 1 : 16;
        else if (dn && !up) m_vol = (m_vol > 0) ? m_vol - 1 : 0;
    endtask

    task automatic compare_all();
        chk("sample_valid", s_valid, m_valid);
        chk("sample_out", s_out, m_out);
        chk("volume", vol, m_vol);
        chk("gain", gain, m_gain);
        chk("ramping", ramping, m_ramp);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic frame(input logic [15:0] s);
        s_in = s; nf = 1'b1;
        step();
        nf = 1'b0;
    endtask

    task automatic sync_reset_cycle();
        rst = 1'b1; #1;
        model_reset();
        compare_all();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        model_reset();
        #12;
        compare_all();
        chk("reset_volume", vol, 12);
        chk("reset_gain", gain, 12);
        chk("reset_sample_out", s_out, 0);
        chk("reset_valid", s_valid, 0);
        chk("reset_ramping", ramping, 0);
        rst = 1'b0;

        // first frame after release scales by the reset gain of 12
        frame(16'h4000);
        chk("first_frame_out", s_out, 16'h3000);
        chk("first_frame_valid", s_valid, 1);
        step();
        chk("valid_one_clk", s_valid, 0);
        chk("out_held", s_out, 16'h3000);

        repeat (5) begin
            up = 1'b1; step(); up = 1'b0;
        end
        chk("vol_saturate_16", vol, 16);
        n = SOFT ? 4 * TB_DIV : 1;
        for (int i = 0; i < n; i++) begin
            frame(16'(i * 97));
            step();
        end
        chk("gain_reaches_16", gain, 16);
        chk("ramp_done", ramping, 0);
        frame(16'h8000);
        chk("unity_min", s_out, 16'h8000);
        frame(16'h7fff);
        chk("unity_max", s_out, 16'h7fff);

        up = 1'b1; dn = 1'b1; step(); up = 1'b0; dn = 1'b0;
        chk("updown_same_clk", vol, 16);
        dn = 1'b1;
        repeat (18) step();
        dn = 1'b0;
        chk("vol_saturate_0", vol, 0);

        sync_reset_cycle();
        mute = 1'b1;
        n = SOFT ? 12 * TB_DIV : 1;
        for (int i = 0; i < n; i++) begin
            frame(16'h1234);
            if (SOFT && i == n - 2) begin
                chk("mute_gain_1", gain, 1);
                chk("mute_ramping", ramping, 1);
            end
        end
        chk("mute_gain_0", gain, 0);
        step();
        chk("mute_ramping_low", ramping, 0);
        frame(16'h7fff);
        chk("mute_out_0", s_out, 0);

        sync_reset_cycle();
        n = SOFT ? 5 * TB_DIV : 1;
        for (int i = 0; i < n; i++) frame(16'h5a5a);
        chk("midramp_gain", gain, SOFT ? 7 : 0);
        chk("midramp_ramping", ramping, SOFT ? 1 : 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_gain", gain, 12);
        chk("async_out", s_out, 0);
        chk("async_valid", s_valid, 0);
        chk("async_ramping", ramping, 0);
        nf = 1'b1; up = 1'b1;
        step();
        nf = 1'b0; up = 1'b0;
        rst = 1'b0;
        mute = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            nf   = ($urandom_range(0, 2) == 0);
            s_in = 16'($urandom);
            up   = ($urandom_range(0, 11) == 0);
            dn   = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 59) == 0) mute = ~mute;
            if ($urandom_range(0, 699) == 0) begin
                rst = 1'b1; #1;
                model_reset();
                compare_all();
            end
            step();
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
